// File: rtl/muxn_rr.sv
// N-to-1 registered channel multiplexer: explicit select (mode=0) or round-robin (mode=1).
// Defining MUXN_PARITY_EN adds out_par, the even parity of the registered word.
module muxn_rr #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   s,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_sel
`ifdef MUXN_PARITY_EN
    ,
    output logic               out_par
`endif
);

    // Handshake: a word moves on any edge where valid and ready are both 1 on
    // the same channel. in_ready never depends on in_valid of another cycle,
    // and out_valid stays high with stable data until out_ready is seen.
    logic [SEL_W-1:0] ptr;
    logic             loadable;
    logic             grant_vld;
    int               grant_idx;
    int               cand;
    logic             xfer;
    logic [WIDTH-1:0] sel_word;

    always_comb begin
        loadable  = !reset && (!out_valid || out_ready);
        grant_vld = 1'b0;
        grant_idx = 0;
        cand      = 0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (int'(s) == i && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = i;
                end
            end
        end else begin
            // Walk downward so the last hit is the nearest channel at or after ptr.
            for (int k = N - 1; k >= 0; k--) begin
                cand = int'(ptr) + k;
                if (cand >= N) cand = cand - N;
                for (int i = 0; i < N; i++) begin
                    if (i == cand && in_valid[i]) begin
                        grant_vld = 1'b1;
                        grant_idx = i;
                    end
                end
            end
        end

        xfer     = loadable && grant_vld;
        in_ready = '0;
        sel_word = '0;
        for (int i = 0; i < N; i++) begin
            if (i == grant_idx) begin
                in_ready[i] = xfer;
                sel_word    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
`ifdef MUXN_PARITY_EN
            out_par   <= 1'b0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_word;
            out_sel   <= SEL_W'(grant_idx);
`ifdef MUXN_PARITY_EN
            out_par   <= ^sel_word;
`endif
            if (mode) ptr <= SEL_W'((grant_idx + 1) % N);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_muxn_rr.sv
// Self-checking bench for muxn_rr: directed scenarios then randomized traffic
// against a grant/queue reference model.
module tb_muxn_rr;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SEL_W = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SEL_W-1:0]   s;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SEL_W-1:0]   out_sel;
`ifdef MUXN_PARITY_EN
    logic               out_par;
`endif

    muxn_rr #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .s         (s),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
`ifdef MUXN_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int               m_ptr   = 0;
    bit               m_valid = 0;
    logic [WIDTH-1:0] m_data  = '0;
    int               m_sel   = 0;
    logic [WIDTH-1:0] exp_q[$];

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    // Driver tasks
    task automatic drive(input logic md, input logic [SEL_W-1:0] sel,
                         input logic [N-1:0] vld, input logic ordy);
        mode      = md;
        s         = sel;
        in_valid  = vld;
        out_ready = ordy;
    endtask

    task automatic set_ch(input int ch, input logic [WIDTH-1:0] w);
        in_data[ch*WIDTH +: WIDTH] = w;
    endtask

    // One clock: check in_ready mid-cycle, update the model, check registered outputs.
    task automatic tick();
        logic [N-1:0]     exp_rdy;
        logic [WIDTH-1:0] word;
        bit               gv;
        bit               loadable;
        int               g;
        @(negedge clk);
        loadable = !reset && (!m_valid || out_ready);
        gv = 0;
        g  = 0;
        if (mode == 1'b0) begin
            if (int'(s) < N && in_valid[s]) begin
                gv = 1;
                g  = int'(s);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!gv && in_valid[c]) begin
                    gv = 1;
                    g  = c;
                end
            end
        end
        exp_rdy = '0;
        if (loadable && gv) exp_rdy[g] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));

        if (!reset && m_valid && out_ready) begin
            if (exp_q.size() > 0) chk("consumed_word", 32'(out_data), 32'(exp_q.pop_front()));
            else chk("consume_underflow", 32'(exp_q.size()), 32'd1);
        end

        if (reset) begin
            m_valid = 0;
            m_data  = '0;
            m_sel   = 0;
            m_ptr   = 0;
            exp_q.delete();
        end else if (loadable && gv) begin
            word = in_data[g*WIDTH +: WIDTH];
            exp_q.push_back(word);
            m_valid = 1;
            m_data  = word;
            m_sel   = g;
            if (mode) m_ptr = (g + 1) % N;
        end else if (out_ready) begin
            m_valid = 0;
        end

        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_sel", 32'(out_sel), 32'(m_sel));
`ifdef MUXN_PARITY_EN
        chk("out_par", 32'(out_par), 32'(^m_data));
`endif
    endtask

    int rr_seq[5]   = '{0, 1, 2, 3, 0};
    int rr_seq2[3]  = '{3, 0, 3};
    logic [WIDTH-1:0] held;

    initial begin
        // Reset with all channels offering words: in_ready must stay zero.
        reset   = 1'b1;
        in_data = '0;
        for (int i = 0; i < N; i++) set_ch(i, WIDTH'(8'h10 + i));
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        tick();
        tick();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        reset = 1'b0;

        // Explicit select of channel 2.
        set_ch(2, 8'hA5);
        drive(1'b0, 2'd2, 4'b0100, 1'b1);
        tick();
        chk("sel2_data", 32'(out_data), 32'h A5);
        chk("sel2_sel", 32'(out_sel), 32'd2);
        drive(1'b0, 2'd2, 4'b0000, 1'b1);
        tick();
        chk("sel2_drain", 32'(out_valid), 32'd0);

        // Round-robin over all channels from ptr=0.
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_full_seq", 32'(out_sel), 32'(rr_seq[i]));
        end

        // ptr is now 1; only channels 0 and 3 offer.
        drive(1'b1, 2'd0, 4'b1001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rr_sparse_seq", 32'(out_sel), 32'(rr_seq2[i]));
        end

        // Backpressure: held word stays put and nothing is accepted.
        drive(1'b1, 2'd0, 4'b1111, 1'b0);
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", 32'(out_data), 32'(held));
        end
        set_ch(1, 8'h3C);
        drive(1'b0, 2'd1, 4'b0010, 1'b1);
        tick();
        chk("reload_valid", 32'(out_valid), 32'd1);
        chk("reload_data", 32'(out_data), 32'h3C);

        // Selected channel idle: nothing granted, output drains.
        drive(1'b0, 2'd2, 4'b1011, 1'b1);
        tick();
        chk("idle_sel_drain", 32'(out_valid), 32'd0);

        // Reset while a word is held discards it.
        set_ch(0, 8'h07);
        drive(1'b0, 2'd0, 4'b0001, 1'b0);
        tick();
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_reset_valid", 32'(out_valid), 32'd0);
        chk("mid_reset_data", 32'(out_data), 32'd0);
        reset = 1'b0;
        drive(1'b0, 2'd0, 4'b0001, 1'b1);
        tick();
        chk("ch0_07_data", 32'(out_data), 32'h07);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) set_ch(i, WIDTH'($urandom_range(0, 255)));
            drive(1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, N - 1)),
                  N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 3) != 0));
            reset = ($urandom_range(0, 49) == 0);
            tick();
        end
        reset = 1'b0;

        chk("queue_depth", 32'(exp_q.size()), 32'(m_valid));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muxn_rr.md
MUXN_RR -- requirements
Module: muxn_rr

Interface
REQ-001 Parameter WIDTH, default 8: data width per channel, 1..32.
REQ-002 Parameter N, default 4: number of input channels, 2..16.
REQ-003 Parameter SEL_W, default 2: select width, with 2**SEL_W >= N.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  channel i offers a word.
REQ-008 in_ready  output  N  channel i word is accepted this cycle.
REQ-009 mode  input  1  0 = explicit select via s; 1 = round-robin.
REQ-010 s  input  SEL_W  channel select, used only when mode=0.
REQ-011 out_data  output  WIDTH  registered selected word.
REQ-012 out_valid  output  1  out_data holds an unconsumed word.
REQ-013 out_ready  input  1  downstream consumes the word when out_valid=1.
REQ-014 out_sel  output  SEL_W  source channel of the current out_data.

Function
REQ-015 A single output register shall be loadable when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
REQ-016 Grant in mode 0: channel s, when s<N and in_valid[s]=1; s>=N grants nothing and all in_ready are 0.
REQ-017 Grant in mode 1: the first channel with in_valid=1, searching upward from pointer ptr with wrap from N-1 to 0.
REQ-018 in_ready shall be one-hot on the granted channel when the register is loadable, and all-zero otherwise; it is combinational from current inputs and state.
REQ-019 On a transfer (in_valid[g] and in_ready[g]): out_data <= word g, out_sel <= g, out_valid <= 1; latency is exactly one clock from input to output.
REQ-020 On out_ready=1 with no transfer in the same cycle, out_valid <= 0; out_data and out_sel hold their values.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_sel shall stay stable and all in_ready shall be 0.
REQ-022 ptr updates to (g+1) mod N only on a mode-1 transfer; ptr holds in mode 0 and when nothing is transferred.
REQ-023 Changing mode or s between cycles shall not corrupt the held word; the new mode applies to the next grant only.
REQ-024 With no valid input, or the register not loadable, no state other than the out_valid clear (REQ-020) shall change.

Reset
REQ-025 While reset=1 at a clk edge: out_valid=0, out_data=0, out_sel=0, ptr=0; in_ready shall read all-zero during reset.
REQ-026 Reset asserted mid-operation shall discard any held word without presenting it.

Configuration
REQ-027 Macro MUXN_PARITY_EN defined: add output port out_par (1 bit), the registered even parity (XOR) of out_data, updated with out_data and reset to 0.
REQ-028 Macro MUXN_PARITY_EN undefined: port out_par does not exist; all other behaviour is identical.

Verification (N=4, WIDTH=8)
REQ-029 Mode 0, s=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=A5, out_sel=2, out_valid=1.
REQ-030 Mode 1, in_valid=4'b1111 held, out_ready=1, ptr=0 -> out_sel sequence 0,1,2,3,0 on consecutive cycles.
REQ-031 Mode 1, in_valid=4'b1001, ptr=1 -> grant order 3, then 0, then 3.
REQ-032 Word loaded, out_ready=0 for 3 cycles -> out_data stable and in_ready=0; out_ready=1 with ch1 valid -> same-cycle consume and reload, out_valid stays 1.
REQ-033 Mode 0 with s=2 and in_valid[2]=0 -> in_ready=0; out_valid drops after consumption.
REQ-034 Reset pulsed while out_valid=1 -> out_valid=0 and out_data=0 next cycle; with MUXN_PARITY_EN, ch0=8'h07 -> out_par=1.
